// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: three writeback source handshakes plus the shared register-file write port
interface wb_port_arbiter_if #(parameter int XLEN = 64);
    logic            alu_valid, alu_ready;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            mem_valid, mem_ready;
    logic [4:0]      mem_rd;
    logic [XLEN-1:0] mem_data;
    logic            mdu_valid, mdu_ready;
    logic [4:0]      mdu_rd;
    logic [XLEN-1:0] mdu_data;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [1:0]      grant_src;
    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, mdu_valid, mdu_rd, mdu_data,
        input  alu_ready, mem_ready, mdu_ready, rf_we, rf_waddr, rf_wdata, grant_src
    );
    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, mdu_valid, mdu_rd, mdu_data,
        output alu_ready, mem_ready, mdu_ready, rf_we, rf_waddr, rf_wdata, grant_src
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: grants one writeback source per cycle onto the registered register-file write port
module wb_port_arbiter #(
    parameter int XLEN         = 64,
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               rst,
    wb_port_arbiter_if.slave  bus
);
    localparam int W = $clog2(STARVE_LIMIT + 1);
    localparam logic [W-1:0] LIM = W'(STARVE_LIMIT);
    logic [W-1:0]    wc_alu, wc_mem, wc_mdu;
    logic [1:0]      sel;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    function automatic logic [W-1:0] wc_next(input logic v, input logic r, input logic [W-1:0] wc);
        return (!v || r) ? '0 : (wc == LIM) ? wc : wc + 1'b1;
    endfunction
    // starved sources win in reverse priority (MDU > ALU > MEM), then base MEM > ALU > MDU
    always_comb begin
        sel = rst                               ? 2'd0 :
              bus.mdu_valid && wc_mdu == LIM    ? 2'd3 :
              bus.alu_valid && wc_alu == LIM    ? 2'd1 :
              bus.mem_valid                     ? 2'd2 :
              bus.alu_valid                     ? 2'd1 :
              bus.mdu_valid                     ? 2'd3 : 2'd0;
        rd   = sel == 2'd1 ? bus.alu_rd   : sel == 2'd2 ? bus.mem_rd   : bus.mdu_rd;
        data = sel == 2'd1 ? bus.alu_data : sel == 2'd2 ? bus.mem_data : bus.mdu_data;
    end
    assign bus.alu_ready = sel == 2'd1;
    assign bus.mem_ready = sel == 2'd2;
    assign bus.mdu_ready = sel == 2'd3;
    always_ff @(posedge clk) begin
        if (rst) begin
            wc_alu        <= '0;
            wc_mem        <= '0;
            wc_mdu        <= '0;
            bus.rf_we     <= 1'b0;
            bus.rf_waddr  <= '0;
            bus.rf_wdata  <= '0;
            bus.grant_src <= 2'd0;
        end else begin
            wc_alu        <= wc_next(bus.alu_valid, sel == 2'd1, wc_alu);
            wc_mem        <= wc_next(bus.mem_valid, sel == 2'd2, wc_mem);
            wc_mdu        <= wc_next(bus.mdu_valid, sel == 2'd3, wc_mdu);
            bus.rf_we     <= sel != 2'd0 && rd != 5'd0;
            bus.grant_src <= sel;
            if (sel != 2'd0) begin
                bus.rf_waddr <= rd;
                bus.rf_wdata <= data;
            end
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed checks of priority, starvation promotion, x0 writes and reset
module tb_wb_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    wb_port_arbiter_if #(.XLEN(64)) bus ();
    wb_port_arbiter #(.XLEN(64), .STARVE_LIMIT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic chk_rdy(input string tag, input logic a, input logic m, input logic d);
        chk({tag, " alu_ready"}, 64'(bus.alu_ready), 64'(a));
        chk({tag, " mem_ready"}, 64'(bus.mem_ready), 64'(m));
        chk({tag, " mdu_ready"}, 64'(bus.mdu_ready), 64'(d));
    endtask
    task automatic chk_out(input string tag, input logic we, input logic [4:0] a, input logic [63:0] d, input logic [1:0] g);
        chk({tag, " rf_we"}, 64'(bus.rf_we), 64'(we));
        chk({tag, " rf_waddr"}, 64'(bus.rf_waddr), 64'(a));
        chk({tag, " rf_wdata"}, bus.rf_wdata, d);
        chk({tag, " grant_src"}, 64'(bus.grant_src), 64'(g));
    endtask
    initial begin
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 64'h1;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd2; bus.mem_data = 64'h2;
        bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd3; bus.mdu_data = 64'h3;
        #1;
        chk_rdy("reset comb", 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk_rdy("reset", 1'b0, 1'b0, 1'b0);
        chk_out("reset", 1'b0, 5'd0, 64'h0, 2'd0);
        rst = 1'b0;
        bus.alu_valid = 1'b0; bus.mem_valid = 1'b0; bus.mdu_valid = 1'b0;
        tick();
        chk_out("idle", 1'b0, 5'd0, 64'h0, 2'd0);
        // single ALU request
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 64'hBBBB_BBBB_BBBB_BBBB;
        #1;
        chk_rdy("alu", 1'b1, 1'b0, 1'b0);
        tick();
        bus.alu_valid = 1'b0;
        chk_out("alu", 1'b1, 5'd7, 64'hBBBB_BBBB_BBBB_BBBB, 2'd1);
        // three-way conflict resolved by base priority
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd12; bus.mem_data = 64'hDEAD_BEEF_DEAD_BEEF;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5;  bus.alu_data = 64'h5555;
        bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd9;  bus.mdu_data = 64'h9999;
        #1;
        chk_rdy("conf1", 1'b0, 1'b1, 1'b0);
        tick();
        bus.mem_valid = 1'b0;
        chk_out("conf1", 1'b1, 5'd12, 64'hDEAD_BEEF_DEAD_BEEF, 2'd2);
        #1;
        chk_rdy("conf2", 1'b1, 1'b0, 1'b0);
        tick();
        bus.alu_valid = 1'b0;
        chk_out("conf2", 1'b1, 5'd5, 64'h5555, 2'd1);
        #1;
        chk_rdy("conf3", 1'b0, 1'b0, 1'b1);
        tick();
        bus.mdu_valid = 1'b0;
        chk_out("conf3", 1'b1, 5'd9, 64'h9999, 2'd3);
        tick();
        chk_out("hold", 1'b0, 5'd9, 64'h9999, 2'd0);
        // starvation: MDU promoted after four waiting cycles, beating the starved ALU too
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd20; bus.alu_data = 64'h2020;
        bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd3;  bus.mdu_data = 64'h3333;
        bus.mem_valid = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            bus.mem_rd = 5'(10 + c); bus.mem_data = 64'(c);
            #1;
            chk_rdy($sformatf("starve%0d", c), 1'b0, 1'b1, 1'b0);
            chk($sformatf("starve%0d wc_mdu", c), 64'(dut.wc_mdu), 64'(c - 1));
            tick();
            chk_out($sformatf("starve%0d", c), 1'b1, 5'(10 + c), 64'(c), 2'd2);
        end
        bus.mem_rd = 5'd15; bus.mem_data = 64'h5;
        #1;
        chk_rdy("starve5", 1'b0, 1'b0, 1'b1);
        chk("starve5 wc_mdu", 64'(dut.wc_mdu), 64'd4);
        tick();
        bus.mdu_valid = 1'b0;
        chk_out("starve5", 1'b1, 5'd3, 64'h3333, 2'd3);
        chk("starve5 wc_mdu cleared", 64'(dut.wc_mdu), 64'd0);
        #1;
        chk_rdy("starve6", 1'b1, 1'b0, 1'b0);
        tick();
        bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
        chk_out("starve6", 1'b1, 5'd20, 64'h2020, 2'd1);
        // write to x0 is accepted but not enabled
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd0; bus.mem_data = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        chk_rdy("x0", 1'b0, 1'b1, 1'b0);
        tick();
        bus.mem_valid = 1'b0;
        chk_out("x0", 1'b0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2'd2);
        // reset while MDU is waiting
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd8; bus.mem_data = 64'h8888;
        bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd4; bus.mdu_data = 64'h4444;
        tick();
        tick();
        tick();
        chk("pre-rst wc_mdu", 64'(dut.wc_mdu), 64'd3);
        rst = 1'b1;
        #1;
        chk_rdy("mid rst", 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        chk_out("mid rst", 1'b0, 5'd0, 64'h0, 2'd0);
        chk("mid rst wc_mdu", 64'(dut.wc_mdu), 64'd0);
        #1;
        chk_rdy("post rst", 1'b0, 1'b1, 1'b0);
        tick();
        chk_out("post rst", 1'b1, 5'd8, 64'h8888, 2'd2);
        chk("post rst wc_mdu", 64'(dut.wc_mdu), 64'd1);
        bus.mem_valid = 1'b0; bus.mdu_valid = 1'b0;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
